// File: rtl/popcount_decode_4.sv
// popcount_decode_4: emits every 4-bit code of weight k (or 4-k when inverted), ascending, one per i_READY handshake.
// One candidate per edge starting the edge after START; the slot holds under stall; o_INDEX when POPCOUNT_DECODE_INDEX_EN.
module popcount_decode_4 (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_START,
  input  logic [2:0] i_COUNT,
  input  logic       i_INVERSE,
  input  logic       i_READY,
  output logic       o_VALID,
  output logic [3:0] o_PATTERN,
  output logic       o_LAST,
  output logic       o_BUSY,
`ifdef POPCOUNT_DECODE_INDEX_EN
  output logic [2:0] o_INDEX,
`endif
  output logic       o_ERROR
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [3:0] cand;
  logic [2:0] target;
  logic       final_loaded;

  logic [2:0] cand_ones;
  logic [3:0] final_code;
  logic       slot_free;
  logic       cand_match;
  logic       cand_final;
  logic       accept_last;

  always_comb begin
    cand_ones = 3'(cand[0]) + 3'(cand[1]) + 3'(cand[2]) + 3'(cand[3]);
    // Largest code of a given weight: its ones packed into the MSBs
    case (target)
      3'd0:    final_code = 4'b0000;
      3'd1:    final_code = 4'b1000;
      3'd2:    final_code = 4'b1100;
      3'd3:    final_code = 4'b1110;
      default: final_code = 4'b1111;
    endcase
    slot_free   = !o_VALID || i_READY;
    cand_match  = (cand_ones == target);
    cand_final  = (cand == final_code);
    accept_last = o_VALID && o_LAST && i_READY;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state        <= IDLE;
      cand         <= 4'd0;
      target       <= 3'd0;
      final_loaded <= 1'b0;
      o_VALID      <= 1'b0;
      o_PATTERN    <= 4'd0;
      o_LAST       <= 1'b0;
      o_BUSY       <= 1'b0;
      o_ERROR      <= 1'b0;
`ifdef POPCOUNT_DECODE_INDEX_EN
      o_INDEX      <= 3'd0;
`endif
    end else begin
      o_ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (i_START) begin
            if (i_COUNT > 3'd4) begin
              o_ERROR <= 1'b1;
            end else begin
              target       <= i_INVERSE ? (3'd4 - i_COUNT) : i_COUNT;
              cand         <= 4'd0;
              final_loaded <= 1'b0;
              o_BUSY       <= 1'b1;
              state        <= RUN;
`ifdef POPCOUNT_DECODE_INDEX_EN
              o_INDEX      <= 3'd0;
`endif
            end
          end
        end
        RUN: begin
`ifdef POPCOUNT_DECODE_INDEX_EN
          if (o_VALID && i_READY)
            o_INDEX <= o_INDEX + 3'd1;
`endif
          if (accept_last) begin
            o_VALID <= 1'b0;
            o_LAST  <= 1'b0;
            o_BUSY  <= 1'b0;
            state   <= IDLE;
          end else if (slot_free && !final_loaded) begin
            if (cand_match) begin
              o_PATTERN    <= cand;
              o_VALID      <= 1'b1;
              o_LAST       <= cand_final;
              final_loaded <= cand_final;
            end else begin
              o_VALID <= 1'b0;
            end
            // Freeze on the final match so the candidate never wraps past 15
            if (!(cand_match && cand_final))
              cand <= cand + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/popcount_decode_4.md
# popcount_decode_4

Inverse companion to the 4-bit population-count encoder. It takes a bit count and emits, one per handshake, every 4-bit value with exactly that many ones, in ascending order. With inversion selected, it emits values with that many zeros instead. Used by pattern generators and test sequencers that need to enumerate all codes of a given Hamming weight.

## Interface
- No parameters; width fixed at 4 bits.
- i_CLK  input  1  clock; all state updates on rising edge.
- i_RST  input  1  reset, asynchronous, active-high.
- i_START  input  1  request a new enumeration; sampled only in IDLE.
- i_COUNT  input  3  requested bit count k; legal range 0..4.
- i_INVERSE  input  1  1 = k counts zeros (target ones = 4-k); 0 = k counts ones.
- i_READY  input  1  downstream accepts o_PATTERN this cycle.
- o_VALID  output  1  o_PATTERN holds a valid pattern.
- o_PATTERN  output  4  current enumerated value.
- o_LAST  output  1  qualifies o_PATTERN as the final value of the enumeration.
- o_BUSY  output  1  enumeration in progress (state RUN).
- o_ERROR  output  1  one-cycle pulse: START with k>4 rejected.

## Operation
- States: IDLE, RUN.
- IDLE, on i_START=1:
  - If k<=4: latch target t = i_INVERSE ? 4-k : k, clear candidate counter c to 0, go to RUN.
  - If k>4: pulse o_ERROR for 1 cycle and stay IDLE.
- RUN, each edge where the output slot is free (o_VALID=0 or i_READY=1):
  - Evaluate candidate c.
  - If popcount(c)==t: load o_PATTERN<=c and o_VALID<=1. Also set o_LAST<=1 when c equals the final match for t (t=0→0, 1→8, 2→12, 3→14, 4→15).
  - If there is no match and the slot was freed by a handshake: o_VALID<=0.
  - Increment c by 1 (4-bit).
- Once the final match is loaded, c stops advancing. The block returns to IDLE on the edge where that pattern is accepted: o_VALID=1, o_LAST=1, i_READY=1. o_VALID and o_LAST clear on that edge.
- Slot held (o_VALID=1, i_READY=0): o_PATTERN, o_LAST and c hold. No pattern is dropped or duplicated.
- Sequence lengths are 1, 4, 6, 4, 1 for t=0..4. c never wraps past 15.
- i_START, i_COUNT and i_INVERSE are ignored in RUN.
- i_READY is ignored while o_VALID=0.

## Timing
- Reset values: o_VALID=0, o_PATTERN=0, o_LAST=0, o_BUSY=0, o_ERROR=0, state IDLE, c=0. o_INDEX=0 when it is present.
- Reset asserted mid-enumeration aborts immediately. The next i_START after reset release starts a fresh sequence.
- START is accepted at edge E0, and o_BUSY=1 after E0. Candidate 0 is evaluated at E1.
- A pattern equal to value v appears after edge E(v+1) when i_READY is held at 1. Full rate, no bubbles between evaluations.
- Example: t=2 with continuous ready gives patterns valid after E4, E6, E7, E10, E11 and E13.
- o_BUSY falls on the edge that accepts the last pattern. A new i_START is accepted no earlier than the following edge.
- o_ERROR is high for exactly the one cycle after the rejecting edge.

## Configuration
- Macro: POPCOUNT_DECODE_INDEX_EN.
- Defined:
  - Adds output port o_INDEX (3 bits): the ordinal of o_PATTERN within the sequence, starting at 0.
  - o_INDEX is valid with o_VALID, holds under stall, and increments on each accepted pattern.
  - It resets to 0 on reset and at each START acceptance.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Test plan
- k=2, inverse=0, ready=1 → o_PATTERN 3,5,6,9,10,12. o_LAST only on 12, o_ERROR=0, o_BUSY falls after 12 is accepted.
- k=1, inverse=1 (target 3 ones), ready=1 → 7,11,13,14 with o_LAST on 14. Then k=4, inverse=1 → single pattern 0 with o_LAST=1.
- k=2, ready low for 3 cycles while o_PATTERN=3 → 3 held stable with o_VALID=1. After ready rises, 5 follows; no loss or repeat.
- k=5 in IDLE → o_ERROR=1 for one cycle; o_BUSY, o_VALID and o_PATTERN stay 0. i_START pulsed while in RUN → no effect on the sequence.
- i_RST pulsed after the second pattern of k=2 → all outputs 0 asynchronously. A new START with k=3 then yields 7,11,13,14.
- With POPCOUNT_DECODE_INDEX_EN defined, k=3 → o_INDEX 0,1,2,3 alongside 7,11,13,14, stable under a ready stall.
